// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports (port 1 wins on collision),
// NUM_RD combinational read ports, optional write bypass, hardware zero sweep.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  output logic                     ready_o,
  input  logic                     wr0_en_i,
  input  logic [AW-1:0]            wr0_addr_i,
  input  logic [XLEN-1:0]          wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [AW-1:0]            wr1_addr_i,
  input  logic [XLEN-1:0]          wr1_data_i,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] mem [NREGS];

  logic wr_ok;
  logic wr0_eff, wr1_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d   = ST_READY;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      ST_READY: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign ready_o = (state_q == ST_READY);

  // A write is effective only in READY without a clear request, and never to a hardwired r0.
  assign wr_ok   = (state_q == ST_READY) && !clear_i;
  assign wr0_eff = wr_ok && wr0_en_i && !((ZERO_REG != 0) && (wr0_addr_i == '0));
  assign wr1_eff = wr_ok && wr1_en_i && !((ZERO_REG != 0) && (wr1_addr_i == '0));

  // Port 1 is assigned last so it overrides port 0 on an address collision.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_idx_q] <= '0;
    end else begin
      if (wr0_eff) mem[wr0_addr_i] <= wr0_data_i;
      if (wr1_eff) mem[wr1_addr_i] <= wr1_data_i;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = rd_addr_i[gi*AW +: AW];

    always_comb begin
      rd = mem[ra];
      if ((BYPASS != 0) && wr0_eff && (wr0_addr_i == ra)) rd = wr0_data_i;
      if ((BYPASS != 0) && wr1_eff && (wr1_addr_i == ra)) rd = wr1_data_i;
      if ((state_q != ST_READY) || ((ZERO_REG != 0) && (ra == '0))) rd = '0;
    end

    assign rd_data_o[gi*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (bypass on) and a 64-bit/16-entry/3-read
// instance (bypass off) driven in lockstep, checked against a reference memory model.
module tb_regfile_mp;

  localparam int AX = 32, AN = 32, AA = 5, AR = 2;
  localparam int BX = 64, BN = 16, BA = 4, BR = 3;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  checks   = 0;
  int  failures = 0;

  logic clk = 1'b0;
  logic rst_n;

  logic            a_clear, a_ready, a_w0en, a_w1en;
  logic [AA-1:0]   a_w0a, a_w1a;
  logic [AX-1:0]   a_w0d, a_w1d;
  logic [AR*AA-1:0] a_rda;
  logic [AR*AX-1:0] a_rdd;

  logic            b_clear, b_ready, b_w0en, b_w1en;
  logic [BA-1:0]   b_w0a, b_w1a;
  logic [BX-1:0]   b_w0d, b_w1d;
  logic [BR*BA-1:0] b_rda;
  logic [BR*BX-1:0] b_rdd;

  logic [AX-1:0] ma [AN];
  logic [BX-1:0] mb [BN];

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .clear_i(a_clear), .ready_o(a_ready),
    .wr0_en_i(a_w0en), .wr0_addr_i(a_w0a), .wr0_data_i(a_w0d),
    .wr1_en_i(a_w1en), .wr1_addr_i(a_w1a), .wr1_data_i(a_w1d),
    .rd_addr_i(a_rda), .rd_data_o(a_rdd)
  );

  regfile_mp #(.XLEN(BX), .NREGS(BN), .NUM_RD(BR), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_i(b_clear), .ready_o(b_ready),
    .wr0_en_i(b_w0en), .wr0_addr_i(b_w0a), .wr0_data_i(b_w0d),
    .wr1_en_i(b_w1en), .wr1_addr_i(b_w1a), .wr1_data_i(b_w1d),
    .rd_addr_i(b_rda), .rd_data_o(b_rdd)
  );

  // ---------------- scoreboard ----------------
  task automatic push(input string tag, input logic [63:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [63:0] act);
    sb_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", act);
    end else begin
      e = sbq.pop_front();
      assert (act === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, act, e.exp);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [63:0] exp, input logic [63:0] act);
    push(tag, exp);
    chk(act);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [AX-1:0] exp_a(input logic [AA-1:0] addr);
    if (addr == '0) return '0;
    if (a_w1en && !a_clear && a_w1a == addr && a_w1a != '0) return a_w1d;
    if (a_w0en && !a_clear && a_w0a == addr && a_w0a != '0) return a_w0d;
    return ma[addr];
  endfunction

  function automatic logic [BX-1:0] exp_b(input logic [BA-1:0] addr);
    if (addr == '0) return '0;
    return mb[addr];
  endfunction

  task automatic commit_models();
    if (!a_clear) begin
      if (a_w0en && a_w0a != '0) ma[a_w0a] = a_w0d;
      if (a_w1en && a_w1a != '0) ma[a_w1a] = a_w1d;
    end
    if (!b_clear) begin
      if (b_w0en && b_w0a != '0) mb[b_w0a] = b_w0d;
      if (b_w1en && b_w1a != '0) mb[b_w1a] = b_w1d;
    end
  endtask

  task automatic zero_models();
    for (int i = 0; i < AN; i++) ma[i] = '0;
    for (int i = 0; i < BN; i++) mb[i] = '0;
  endtask

  task automatic idle();
    a_clear = 0; a_w0en = 0; a_w1en = 0;
    a_w0a = '0; a_w1a = '0; a_w0d = '0; a_w1d = '0;
    b_clear = 0; b_w0en = 0; b_w1en = 0;
    b_w0a = '0; b_w1a = '0; b_w0d = '0; b_w1d = '0;
  endtask

  // Push lane expectations (zeros while a bank is sweeping), then compare in the same order.
  task automatic push_reads(input bit a_sweep, input bit b_sweep);
    for (int k = 0; k < AR; k++)
      push($sformatf("a_rd%0d_addr%0d", k, a_rda[k*AA +: AA]),
           a_sweep ? 64'd0 : 64'(exp_a(a_rda[k*AA +: AA])));
    for (int k = 0; k < BR; k++)
      push($sformatf("b_rd%0d_addr%0d", k, b_rda[k*BA +: BA]),
           b_sweep ? 64'd0 : exp_b(b_rda[k*BA +: BA]));
  endtask

  task automatic check_reads();
    for (int k = 0; k < AR; k++) chk(64'(a_rdd[k*AX +: AX]));
    for (int k = 0; k < BR; k++) chk(b_rdd[k*BX +: BX]);
  endtask

  // One READY-state transaction: inputs already driven; sample at negedge, commit at posedge.
  task automatic drive_done();
    push_reads(1'b0, 1'b0);
    @(negedge clk);
    check_reads();
    @(posedge clk);
    commit_models();
    #1;
  endtask

  // Edges 1..n after sweep start; inputs of each bank are released once it reports ready.
  task automatic run_sweep(input int n);
    for (int j = 1; j <= n; j++) begin
      @(posedge clk);
      #1;
      if (j >= BN) begin b_clear = 0; b_w0en = 0; b_w1en = 0; end
      if (j >= AN) begin a_clear = 0; a_w0en = 0; a_w1en = 0; end
      #1;
      expect_now($sformatf("a_ready_edge%0d", j), 64'(j >= AN), 64'(a_ready));
      expect_now($sformatf("b_ready_edge%0d", j), 64'(j >= BN), 64'(b_ready));
      push_reads(j < AN, j < BN);
      check_reads();
    end
  endtask

  task automatic read_all();
    idle();
    for (int i = 0; i < AN; i++) begin
      a_rda = {AA'(AN - 1 - i), AA'(i)};
      b_rda = {BA'((i + 9) % BN), BA'((i + 5) % BN), BA'(i % BN)};
      drive_done();
    end
  endtask

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      a_w0en = 1'($urandom); a_w0a = AA'($urandom); a_w0d = $urandom;
      a_w1en = 1'($urandom); a_w1a = AA'($urandom); a_w1d = $urandom;
      b_w0en = 1'($urandom); b_w0a = BA'($urandom); b_w0d = {$urandom, $urandom};
      b_w1en = 1'($urandom); b_w1a = BA'($urandom); b_w1d = {$urandom, $urandom};
      a_rda = {AA'($urandom), AA'(a_w0a)};
      b_rda = {BA'($urandom), BA'(b_w1a), BA'(b_w0a)};
      drive_done();
    end
    idle();
  endtask

  task automatic fill();
    for (int i = 1; i < AN; i++) begin
      idle();
      a_w0en = 1; a_w0a = AA'(i); a_w0d = {8'(i), 8'(~i), 16'hA5A5};
      a_rda = {AA'(i), AA'(i - 1)};
      if (i < BN) begin
        b_w1en = 1; b_w1a = BA'(i); b_w1d = {32'(i), 32'hC0DE_0000 | 32'(i)};
      end
      b_rda = {BA'(i % BN), BA'((i - 1) % BN), BA'(3)};
      drive_done();
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    a_rda = '0; b_rda = '0;
    zero_models();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    expect_now("a_ready_reset", 64'd0, 64'(a_ready));
    expect_now("b_ready_reset", 64'd0, 64'(b_ready));
    @(negedge clk);
    @(negedge clk);

    // Reset sweep with writes to r3 and clear_i held throughout: both must be ignored.
    rst_n = 1'b1;
    a_clear = 1; a_w0en = 1; a_w0a = 5'd3; a_w0d = 32'hBAD0_BAD0;
    b_clear = 1; b_w0en = 1; b_w0a = 4'd3; b_w0d = 64'hBAD0_BAD0_BAD0_BAD0;
    a_rda = {5'd31, 5'd3};
    b_rda = {4'd15, 4'd3, 4'd0};
    run_sweep(AN + 1);
    read_all();

    // Write/read r5 via port 0.
    idle();
    a_w0en = 1; a_w0a = 5'd5; a_w0d = 32'hDEAD_BEEF; a_rda = {5'd6, 5'd5};
    b_w0en = 1; b_w0a = 4'd5; b_w0d = 64'hCAFE_F00D_DEAD_BEEF; b_rda = {4'd5, 4'd6, 4'd5};
    #1;
    expect_now("a_r5_same_cycle", 64'h0000_0000_DEAD_BEEF, 64'(a_rdd[31:0]));
    expect_now("b_r5_same_cycle", 64'd0, b_rdd[63:0]);
    drive_done();
    idle();
    #1;
    expect_now("b_r5_next_cycle", 64'hCAFE_F00D_DEAD_BEEF, b_rdd[63:0]);
    drive_done();

    // Collision on r7: port 1 wins.
    a_w0en = 1; a_w0a = 5'd7; a_w0d = 32'h1111_1111;
    a_w1en = 1; a_w1a = 5'd7; a_w1d = 32'h2222_2222; a_rda = {5'd7, 5'd7};
    b_w0en = 1; b_w0a = 4'd7; b_w0d = 64'h1111_1111_1111_1111;
    b_w1en = 1; b_w1a = 4'd7; b_w1d = 64'h2222_2222_2222_2222; b_rda = {4'd7, 4'd7, 4'd7};
    #1;
    expect_now("a_coll_bypass", 64'h0000_0000_2222_2222, 64'(a_rdd[63:32]));
    drive_done();
    idle();
    #1;
    expect_now("a_coll_stored", 64'h0000_0000_2222_2222, 64'(a_rdd[31:0]));
    expect_now("b_coll_stored", 64'h2222_2222_2222_2222, b_rdd[127:64]);
    drive_done();

    // Writes to r0 through both ports are discarded.
    a_w0en = 1; a_w0a = '0; a_w0d = '1; a_w1en = 1; a_w1a = '0; a_w1d = '1; a_rda = '0;
    b_w0en = 1; b_w0a = '0; b_w0d = '1; b_w1en = 1; b_w1a = '0; b_w1d = '1; b_rda = '0;
    #1;
    expect_now("a_r0_bypass", 64'd0, 64'(a_rdd[31:0]));
    drive_done();
    idle();
    drive_done();

    random_cycles(40);

    // Re-clear with a concurrent write to r3 that must be dropped.
    fill();
    a_clear = 1; a_w0en = 1; a_w0a = 5'd3; a_w0d = 32'h1234_5678; a_rda = {5'd31, 5'd3};
    b_clear = 1; b_w0en = 1; b_w0a = 4'd3; b_w0d = 64'h1234_5678_1234_5678; b_rda = {4'd15, 4'd3, 4'd1};
    push_reads(1'b0, 1'b0);
    @(negedge clk);
    check_reads();
    expect_now("a_ready_before_accept", 64'd1, 64'(a_ready));
    @(posedge clk);
    #1;
    expect_now("a_ready_after_accept", 64'd0, 64'(a_ready));
    expect_now("b_ready_after_accept", 64'd0, 64'(b_ready));
    zero_models();
    a_w0a = 5'd1;
    b_w0a = 4'd1;
    run_sweep(AN + 1);
    read_all();

    // Asynchronous reset in READY, then again mid-sweep at index 10.
    random_cycles(20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_now("a_ready_async", 64'd0, 64'(a_ready));
    expect_now("b_ready_async", 64'd0, 64'(b_ready));
    @(negedge clk);
    rst_n = 1'b1;
    zero_models();
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("a_ready_midsweep", 64'd0, 64'(a_ready));
    @(negedge clk);
    rst_n = 1'b1;
    a_rda = {5'd20, 5'd31};
    b_rda = {4'd12, 4'd14, 4'd15};
    run_sweep(AN + 1);
    read_all();

    if (sbq.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
